// File: rtl/si_pkg.sv
// Shared Space Invaders definitions: screen geometry, palette and the projectile slot record.
// Also holds small arithmetic helpers used by the sprite blocks.
package si_pkg;

   localparam int SCREEN_W = 640;
   localparam int SCREEN_H = 480;

   localparam logic [23:0] COLOR_BLACK  = 24'h000000;
   localparam logic [23:0] COLOR_WHITE  = 24'hFFFFFF;
   localparam logic [23:0] COLOR_YELLOW = 24'hFFFF00;
   localparam logic [23:0] COLOR_GREEN  = 24'h00FF00;

   typedef struct packed {
      logic        active;
      logic [10:0] x;
      logic [9:0]  y;
   } projectile_state_t;

   // Subtraction that clamps at zero instead of wrapping.
   function automatic logic [10:0] sat_sub_11(input logic [10:0] a, input logic [10:0] b);
      return (a >= b) ? (a - b) : 11'd0;
   endfunction

endpackage

// File: rtl/fire_sync_edge.sv
// Two-flop synchroniser for an active-low push button plus a one-cycle press pulse
// on the 1->0 transition of the synchronised level.
module fire_sync_edge (
   input  logic clk,
   input  logic reset,
   input  logic btn_n,
   output logic press
);

   logic sync1_q, sync1_d;
   logic sync2_q, sync2_d;
   logic prev_q,  prev_d;

   // Shift chain: raw key -> two sync stages -> previous synchronised level.
   always_comb begin
      sync1_d = btn_n;
      sync2_d = sync1_q;
      prev_d  = sync2_q;
   end

   // Chain flops; reset to the released (high) level so no spurious press follows reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
         prev_q  <= 1'b1;
      end else begin
         sync1_q <= sync1_d;
         sync2_q <= sync2_d;
         prev_q  <= prev_d;
      end
   end

   assign press = prev_q & ~sync2_q;

endmodule

// File: rtl/projectile_bank.sv
// Multi-shot player projectile bank: fire debounce/cooldown, slot allocation, upward motion,
// retirement at the top or on a kill, and a one-cycle-latency rectangle renderer.
module projectile_bank
   import si_pkg::*;
#(
   parameter int          N_SHOTS   = 4,
   parameter int          IDX_W     = 2,
   parameter int          SHOT_W    = 4,
   parameter int          SHOT_H    = 12,
   parameter int          SPAWN_Y   = 440,
   parameter int          STEP      = 4,
   parameter int          SPEED_DIV = 500000,
   parameter int          COOLDOWN  = 5000000,
   parameter logic [23:0] COLOR     = COLOR_YELLOW
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  btn_fire,
   input  logic [10:0]           posX_Nave,
   input  logic [9:0]            h_counter,
   input  logic [9:0]            v_counter,
   input  logic                  kill_valid,
   input  logic [IDX_W-1:0]      kill_idx,
   output logic [N_SHOTS-1:0]    tiro_ativo,
   output logic [N_SHOTS*11-1:0] shot_x,
   output logic [N_SHOTS*10-1:0] shot_y,
   output logic [11:0]           shots_fired,
   output logic [7:0]            R,
   output logic [7:0]            G,
   output logic [7:0]            B
);

   localparam int TICK_W = (SPEED_DIV > 1) ? $clog2(SPEED_DIV) : 1;
   localparam int CD_W   = (COOLDOWN > 1) ? $clog2(COOLDOWN) : 1;

   logic [TICK_W-1:0] tick_q, tick_d;
   logic [CD_W-1:0]   cd_q, cd_d;
   logic [11:0]       fired_q, fired_d;
   logic [23:0]       rgb_q, rgb_d;

   logic              press_s;
   logic              tick_s;
   logic              fire_ok_s;
   logic              free_found_s;
   logic [IDX_W-1:0]  alloc_idx_s;
   logic [10:0]       spawn_x_s;
   logic [N_SHOTS-1:0] hit_s;

   fire_sync_edge u_fire_sync (
      .clk   (clk),
      .reset (reset),
      .btn_n (btn_fire),
      .press (press_s)
   );

   // Lowest-index free slot, judged on the registered active flags only.
   always_comb begin
      free_found_s = 1'b0;
      alloc_idx_s  = '0;
      for (int i = N_SHOTS - 1; i >= 0; i--) begin
         free_found_s = free_found_s | ~tiro_ativo[i];
         alloc_idx_s  = tiro_ativo[i] ? alloc_idx_s : IDX_W'(i);
      end
   end

   assign tick_s    = (tick_q == TICK_W'(SPEED_DIV - 1));
   assign fire_ok_s = press_s && (cd_q == '0) && free_found_s;
   assign spawn_x_s = sat_sub_11(posX_Nave, 11'(SHOT_W / 2));

   // Motion tick divider, fire cooldown and saturating fire counter.
   always_comb begin
      tick_d  = tick_s ? '0 : (tick_q + TICK_W'(1));
      cd_d    = cd_q;
      fired_d = fired_q;
      if (fire_ok_s) begin
         cd_d = CD_W'(COOLDOWN - 1);
      end else if (cd_q != '0) begin
         cd_d = cd_q - CD_W'(1);
      end else begin
         cd_d = cd_q;
      end
      if (fire_ok_s && (fired_q != 12'hFFF)) begin
         fired_d = fired_q + 12'd1;
      end else begin
         fired_d = fired_q;
      end
   end

   for (genvar i = 0; i < N_SHOTS; i++) begin : g_slot
      projectile_state_t slot_q, slot_d;
      logic              kill_s;

      assign kill_s = kill_valid && (kill_idx == IDX_W'(i));

      // Per-slot update: kill beats motion; only an idle slot can take a spawn.
      always_comb begin
         slot_d = slot_q;
         if (slot_q.active) begin
            if (kill_s) begin
               slot_d.active = 1'b0;
            end else if (tick_s && (slot_q.y < 10'(STEP))) begin
               slot_d.active = 1'b0;
            end else if (tick_s) begin
               slot_d.y = slot_q.y - 10'(STEP);
            end else begin
               slot_d = slot_q;
            end
         end else if (fire_ok_s && (alloc_idx_s == IDX_W'(i))) begin
            slot_d.active = 1'b1;
            slot_d.x      = spawn_x_s;
            slot_d.y      = 10'(SPAWN_Y);
         end else begin
            slot_d = slot_q;
         end
      end

      // Slot state register.
      always_ff @(posedge clk) begin
         if (reset) begin
            slot_q <= '0;
         end else begin
            slot_q <= slot_d;
         end
      end

      assign tiro_ativo[i]        = slot_q.active;
      assign shot_x[i*11 +: 11]   = slot_q.x;
      assign shot_y[i*10 +: 10]   = slot_q.y;
      assign hit_s[i] = slot_q.active
         && ({1'b0, h_counter} >= slot_q.x)
         && ({1'b0, h_counter} <  (slot_q.x + 11'(SHOT_W)))
         && ({1'b0, v_counter} >= {1'b0, slot_q.y})
         && ({1'b0, v_counter} <  ({1'b0, slot_q.y} + 11'(SHOT_H)));
   end

   // Pixel colour for the mixer.
   always_comb begin
      rgb_d = COLOR_BLACK;
      if (|hit_s) begin
         rgb_d = COLOR;
      end else begin
         rgb_d = COLOR_BLACK;
      end
   end

   // Shared control and output registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         tick_q  <= '0;
         cd_q    <= '0;
         fired_q <= 12'd0;
         rgb_q   <= 24'd0;
      end else begin
         tick_q  <= tick_d;
         cd_q    <= cd_d;
         fired_q <= fired_d;
         rgb_q   <= rgb_d;
      end
   end

   assign shots_fired = fired_q;
   assign R           = rgb_q[23:16];
   assign G           = rgb_q[15:8];
   assign B           = rgb_q[7:0];

endmodule

// File: tb/tb_projectile_bank.sv
// Randomised bench for projectile_bank: two instances (spawn rows 440 and 6) compared every
// cycle against a behavioural model driven by edge counts, press history and slot arrays.
module tb_projectile_bank;

   localparam int N         = 4;
   localparam int SPEED_DIV = 4;
   localparam int COOLDOWN  = 8;
   localparam int STEP      = 4;
   localparam int SHOT_W    = 4;
   localparam int SHOT_H    = 12;
   localparam logic [23:0] COLOR = 24'hFFFF00;

   logic        clk = 1'b0;
   logic        reset, btn_fire, kill_valid;
   logic [10:0] pos_x;
   logic [9:0]  h_cnt, v_cnt;
   logic [1:0]  kill_idx;

   logic [3:0]  act0, act1;
   logic [43:0] sx0, sx1;
   logic [39:0] sy0, sy1;
   logic [11:0] sf0, sf1;
   logic [7:0]  r0, g0, b0, r1, g1, b1;

   int errors = 0;
   int checks = 0;

   // model state, index 0 = spawn row 440, index 1 = spawn row 6
   bit          m_act [2][N];
   int          m_x   [2][N];
   int          m_y   [2][N];
   int          m_fired [2];
   int          m_last  [2];
   bit          m_any   [2];
   logic [23:0] m_rgb   [2];
   bit          hist [$];
   int          edge_n;

   always #5 clk = ~clk;

   projectile_bank #(.N_SHOTS(4), .IDX_W(2), .SHOT_W(SHOT_W), .SHOT_H(SHOT_H), .SPAWN_Y(440),
                     .STEP(STEP), .SPEED_DIV(SPEED_DIV), .COOLDOWN(COOLDOWN), .COLOR(COLOR)) dut (
      .clk(clk), .reset(reset), .btn_fire(btn_fire), .posX_Nave(pos_x), .h_counter(h_cnt),
      .v_counter(v_cnt), .kill_valid(kill_valid), .kill_idx(kill_idx), .tiro_ativo(act0),
      .shot_x(sx0), .shot_y(sy0), .shots_fired(sf0), .R(r0), .G(g0), .B(b0));

   projectile_bank #(.N_SHOTS(4), .IDX_W(2), .SHOT_W(SHOT_W), .SHOT_H(SHOT_H), .SPAWN_Y(6),
                     .STEP(STEP), .SPEED_DIV(SPEED_DIV), .COOLDOWN(COOLDOWN), .COLOR(COLOR)) dut_top (
      .clk(clk), .reset(reset), .btn_fire(btn_fire), .posX_Nave(pos_x), .h_counter(h_cnt),
      .v_counter(v_cnt), .kill_valid(kill_valid), .kill_idx(kill_idx), .tiro_ativo(act1),
      .shot_x(sx1), .shot_y(sy1), .shots_fired(sf1), .R(r1), .G(g1), .B(b1));

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic int spawn_row(input int k);
      return (k == 0) ? 440 : 6;
   endfunction

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         for (int i = 0; i < N; i++) begin
            m_act[k][i] = 1'b0; m_x[k][i] = 0; m_y[k][i] = 0;
         end
         m_fired[k] = 0; m_last[k] = 0; m_any[k] = 1'b0; m_rgb[k] = 24'h0;
      end
      hist   = '{1'b1, 1'b1, 1'b1};
      edge_n = 0;
   endtask

   // One rising edge of behaviour, from the inputs present at that edge.
   task automatic model_edge();
      bit press, tick, hit;
      int free, h, v;
      if (reset) begin
         model_reset();
         return;
      end
      press = hist[2] && !hist[1];
      hist.push_front(btn_fire);
      void'(hist.pop_back());
      tick = (edge_n % SPEED_DIV) == (SPEED_DIV - 1);
      h = int'(h_cnt);
      v = int'(v_cnt);
      for (int k = 0; k < 2; k++) begin
         hit = 1'b0;
         for (int i = 0; i < N; i++)
            if (m_act[k][i] && h >= m_x[k][i] && h < m_x[k][i] + SHOT_W &&
                v >= m_y[k][i] && v < m_y[k][i] + SHOT_H) hit = 1'b1;
         m_rgb[k] = hit ? COLOR : 24'h0;
         free = -1;
         for (int i = N - 1; i >= 0; i--) if (!m_act[k][i]) free = i;
         for (int i = 0; i < N; i++) begin
            if (m_act[k][i]) begin
               if (kill_valid && int'(kill_idx) == i) m_act[k][i] = 1'b0;
               else if (tick && m_y[k][i] < STEP)     m_act[k][i] = 1'b0;
               else if (tick)                         m_y[k][i] -= STEP;
            end
         end
         if (press && free >= 0 && (!m_any[k] || edge_n - m_last[k] >= COOLDOWN)) begin
            m_act[k][free] = 1'b1;
            m_x[k][free]   = (int'(pos_x) >= SHOT_W / 2) ? int'(pos_x) - SHOT_W / 2 : 0;
            m_y[k][free]   = spawn_row(k);
            if (m_fired[k] < 4095) m_fired[k]++;
            m_last[k] = edge_n;
            m_any[k]  = 1'b1;
         end
      end
      edge_n++;
   endtask

   task automatic compare_all();
      logic [3:0]  ea;
      logic [43:0] ex;
      logic [39:0] ey;
      for (int k = 0; k < 2; k++) begin
         ea = '0; ex = '0; ey = '0;
         for (int i = 0; i < N; i++) begin
            ea[i] = m_act[k][i];
            ex[i*11 +: 11] = 11'(m_x[k][i]);
            ey[i*10 +: 10] = 10'(m_y[k][i]);
         end
         if (k == 0) begin
            check_eq("y440_active", act0, ea);
            check_eq("y440_shot_x", sx0, ex);
            check_eq("y440_shot_y", sy0, ey);
            check_eq("y440_fired", sf0, 12'(m_fired[0]));
            check_eq("y440_rgb", {r0, g0, b0}, m_rgb[0]);
         end else begin
            check_eq("y6_active", act1, ea);
            check_eq("y6_shot_x", sx1, ex);
            check_eq("y6_shot_y", sy1, ey);
            check_eq("y6_fired", sf1, 12'(m_fired[1]));
            check_eq("y6_rgb", {r1, g1, b1}, m_rgb[1]);
         end
      end
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
      compare_all();
   endtask

   task automatic do_reset();
      reset = 1'b1; btn_fire = 1'b1; kill_valid = 1'b0;
      repeat (3) step();
      reset = 1'b0;
   endtask

   task automatic press_once(input int low_cycles, input int high_cycles);
      btn_fire = 1'b0;
      repeat (low_cycles) step();
      btn_fire = 1'b1;
      repeat (high_cycles) step();
   endtask

   initial begin
      int hold, k, i;
      bit found;
      reset = 1'b1; btn_fire = 1'b1; kill_valid = 1'b0; kill_idx = 2'd0;
      pos_x = 11'd100; h_cnt = 10'd0; v_cnt = 10'd0;
      model_reset();

      do_reset();
      check_eq("rst_active", act0, 4'h0);
      check_eq("rst_rgb", {r0, g0, b0}, 24'h0);
      check_eq("rst_fired", sf0, 12'h0);
      check_eq("rst_shot_y", sy0, 40'h0);

      // single held press
      pos_x = 11'd100;
      btn_fire = 1'b0;
      repeat (20) step();
      btn_fire = 1'b1;
      check_eq("single_active", act0, 4'b0001);
      check_eq("single_x", sx0[10:0], 11'd98);
      check_eq("single_fired", sf0, 12'd1);
      check_eq("single_fired_top", sf1, 12'd1);

      // five presses 10 cycles apart from empty
      do_reset();
      repeat (5) press_once(2, 8);
      check_eq("fill_active", act0, 4'b1111);
      check_eq("fill_fired", sf0, 12'd4);

      // presses 3 cycles apart collide with the cooldown
      do_reset();
      repeat (6) press_once(1, 2);
      repeat (4) step();
      check_eq("cooldown_fired", sf0, 12'd2);

      // kill on a tick cycle, then reuse of the killed slot on the next cycle
      do_reset();
      repeat (2) press_once(2, 8);
      repeat (4) step();
      while ((edge_n % SPEED_DIV) != 2) step();
      btn_fire = 1'b0;
      step();
      kill_valid = 1'b1; kill_idx = 2'd1;
      step();
      kill_valid = 1'b0;
      check_eq("kill_active", act0[1:0], 2'b01);
      step();
      check_eq("kill_realloc", act0[1:0], 2'b11);
      check_eq("kill_realloc_y", sy0[19:10], 10'd440);
      btn_fire = 1'b1;
      repeat (4) step();

      // render edges around a shot sitting at (200,300)
      do_reset();
      pos_x = 11'd202;
      press_once(2, 2);
      found = 1'b0;
      for (int n = 0; n < 400 && !found; n++) begin
         if (m_act[0][0] && m_y[0][0] == 300) found = 1'b1;
         else step();
      end
      check_eq("render_wait", found, 1'b1);
      h_cnt = 10'd203; v_cnt = 10'd311;
      step();
      check_eq("render_hit", {r0, g0, b0}, 24'hFFFF00);
      h_cnt = 10'd204;
      step();
      check_eq("render_h_edge", {r0, g0, b0}, 24'h0);
      h_cnt = 10'd203; v_cnt = 10'd312;
      step();
      check_eq("render_v_edge", {r0, g0, b0}, 24'h0);

      // spawn clamped at the left edge
      do_reset();
      pos_x = 11'd1;
      press_once(2, 4);
      check_eq("clamp_x", sx0[10:0], 11'd0);

      // randomised traffic
      hold = 0;
      for (int n = 0; n < 3000; n++) begin
         reset = ($urandom_range(0, 499) == 0);
         if (hold == 0) begin
            btn_fire = ~btn_fire;
            hold = $urandom_range(1, 12);
         end else begin
            hold--;
         end
         if ($urandom_range(0, 15) == 0)
            pos_x = ($urandom_range(0, 3) == 0) ? 11'($urandom_range(0, 3)) : 11'($urandom_range(0, 639));
         kill_valid = ($urandom_range(0, 7) == 0);
         kill_idx   = 2'($urandom_range(0, 3));
         if ($urandom_range(0, 1) == 0) begin
            k = $urandom_range(0, 1);
            i = $urandom_range(0, N - 1);
            h_cnt = 10'((m_x[k][i] + $urandom_range(0, SHOT_W + 1) + 1023) % 1024);
            v_cnt = 10'((m_y[k][i] + $urandom_range(0, SHOT_H + 1) + 1023) % 1024);
         end else begin
            h_cnt = 10'($urandom_range(0, 1023));
            v_cnt = 10'($urandom_range(0, 1023));
         end
         step();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
